// File: rtl/key_seq_pkg.sv
// Shared types for the key sequencer: FSM states and the mode code read by the GUI.
package key_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2
    } state_e;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_REC  = 2'b01;
    localparam logic [1:0] MODE_PLAY = 2'b10;

    localparam int KEY_W = 4;

    typedef logic [KEY_W-1:0] key_vec_t;

endpackage

// File: rtl/key_seq_ram.sv
// Event buffer: one synchronous write port, one combinational read port, contents not reset.
module key_seq_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 20
) (
    input  logic                     clock,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/key_sequencer.sv
// Key front end: synchronizes raw keys, passes them through, records timed key
// events into a buffer, or replays the stored recording.
module key_sequencer
    import key_seq_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int DUR_W    = 16,
    parameter int TICK_DIV = 50000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [3:0]               raw_keys,
    input  logic                     rec_btn,
    input  logic                     play_btn,
    output logic [3:0]               keys,
    output logic [1:0]               mode,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TICK_DIV);

    localparam logic [CW-1:0]    DEPTH_C   = CW'(DEPTH);
    localparam logic [DUR_W-1:0] DUR_MAX   = '1;
    localparam logic [TW-1:0]    TCNT_LAST = TW'(TICK_DIV - 1);

    typedef struct packed {
        key_vec_t         vec;
        logic [DUR_W-1:0] dur;
    } entry_t;

    state_e           state_q;
    key_vec_t         sync1_q, skeys_q, keys_q, cur_vec_q;
    logic [1:0]       mode_q;
    logic             full_q;
    logic [CW-1:0]    count_q, wr_ptr_q, rd_ptr_q;
    logic [TW-1:0]    tcnt_q;
    logic [DUR_W-1:0] dur_q, rem_q;

    logic             tick, key_chg, dur_sat, we, last_wr;
    logic [CW-1:0]    wr_ptr_d;
    logic [AW-1:0]    raddr;
    entry_t           wr_ent, rd_ent;

    assign tick     = (tcnt_q == TCNT_LAST);
    assign key_chg  = (skeys_q != cur_vec_q);
    assign dur_sat  = tick && (dur_q == DUR_MAX);
    // Stop, key change and saturation all store the open segment; at most one write per cycle.
    assign we       = (state_q == RECORD) && (rec_btn || key_chg || dur_sat);
    assign wr_ptr_d = wr_ptr_q + 1'b1;
    assign last_wr  = we && (wr_ptr_d == DEPTH_C);
    assign wr_ent   = '{vec: cur_vec_q, dur: dur_q};
    // rd_ptr_q holds the index of the next entry to load; IDLE always presents entry 0.
    assign raddr    = (state_q == PLAY) ? rd_ptr_q[AW-1:0] : '0;

    key_seq_ram #(
        .DEPTH (DEPTH),
        .WIDTH (KEY_W + DUR_W)
    ) u_ram (
        .clock   (clock),
        .we_i    (we),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wr_ent),
        .raddr_i (raddr),
        .rdata_o (rd_ent)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            skeys_q   <= '0;
            keys_q    <= '0;
            mode_q    <= MODE_IDLE;
            full_q    <= 1'b0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            tcnt_q    <= '0;
            dur_q     <= '0;
            rem_q     <= '0;
            cur_vec_q <= '0;
            state_q   <= IDLE;
        end else begin
            sync1_q <= raw_keys;
            skeys_q <= sync1_q;
            tcnt_q  <= tick ? '0 : tcnt_q + 1'b1;

            unique case (state_q)
                IDLE: begin
                    keys_q <= skeys_q;
                    if (rec_btn) begin
                        state_q   <= RECORD;
                        mode_q    <= MODE_REC;
                        wr_ptr_q  <= '0;
                        cur_vec_q <= skeys_q;
                        dur_q     <= '0;
                        full_q    <= 1'b0;
                        tcnt_q    <= '0;
                    end else if (play_btn && (count_q != '0)) begin
                        state_q  <= PLAY;
                        mode_q   <= MODE_PLAY;
                        keys_q   <= rd_ent.vec;
                        rem_q    <= rd_ent.dur;
                        rd_ptr_q <= CW'(1);
                        tcnt_q   <= '0;
                    end
                end

                RECORD: begin
                    keys_q <= skeys_q;
                    if (we) begin
                        wr_ptr_q <= wr_ptr_d;
                    end
                    if (key_chg) begin
                        cur_vec_q <= skeys_q;
                        dur_q     <= '0;
                    end else if (dur_sat) begin
                        dur_q <= '0;
                    end else if (tick) begin
                        dur_q <= dur_q + 1'b1;
                    end
                    if (rec_btn || last_wr) begin
                        state_q <= IDLE;
                        mode_q  <= MODE_IDLE;
                        count_q <= wr_ptr_d;
                        full_q  <= last_wr;
                    end
                end

                PLAY: begin
                    if (play_btn) begin
                        state_q <= IDLE;
                        mode_q  <= MODE_IDLE;
                        keys_q  <= skeys_q;
                    end else if (rem_q == '0) begin
                        if (rd_ptr_q == count_q) begin
                            state_q <= IDLE;
                            mode_q  <= MODE_IDLE;
                            keys_q  <= skeys_q;
                        end else begin
                            keys_q   <= rd_ent.vec;
                            rem_q    <= rd_ent.dur;
                            rd_ptr_q <= rd_ptr_q + 1'b1;
                        end
                    end else if (tick) begin
                        rem_q <= rem_q - 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    mode_q  <= MODE_IDLE;
                end
            endcase
        end
    end

    assign keys  = keys_q;
    assign mode  = mode_q;
    assign full  = full_q;
    assign count = count_q;

endmodule
